mlp_seq_engine: RTL

//  Parametrised successor to the fixed 4->4->3 MLP: N hidden ReLU layers plus a linear output layer on one

---
 rtl/mlp_seq_engine_if.sv | 39 +++
 rtl/mlp_seq_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mlp_seq_engine_if.sv
// rtl/mlp_seq_engine_if.sv - start/config/result bundle for the sequential MLP engine
interface mlp_seq_engine_if #(
  parameter int NUM_FEATURES      = 4,
  parameter int HIDDEN_WIDTH      = 4,
  parameter int NUM_HIDDEN_LAYERS = 1,
  parameter int NUM_CLASSES       = 3,
  parameter int FP_TOTAL_BITS     = 16
);
  localparam int NL   = NUM_HIDDEN_LAYERS + 1;
  localparam int D_FH = (NUM_FEATURES > HIDDEN_WIDTH) ? NUM_FEATURES : HIDDEN_WIDTH;
  localparam int D    = (D_FH > NUM_CLASSES) ? D_FH : NUM_CLASSES;
  localparam int LW   = (NL > 1) ? $clog2(NL) : 1;
  localparam int CW   = (D > 1) ? $clog2(D) : 1;
  localparam int KW   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                                         start;
  logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]   x;
  logic                                         cfg_we;
  logic                                         cfg_bias;
  logic [LW-1:0]                                cfg_layer;
  logic [CW-1:0]                                cfg_row;
  logic [CW-1:0]                                cfg_col;
  logic [FP_TOTAL_BITS-1:0]                     cfg_wdata;
  logic                                         busy;
  logic [NUM_CLASSES-1:0][FP_TOTAL_BITS-1:0]    mlp_out;
  logic [KW-1:0]                                class_idx;
  logic                                         sat_flag;
  logic                                         done;

  modport master (
    output start, x, cfg_we, cfg_bias, cfg_layer, cfg_row, cfg_col, cfg_wdata,
    input  busy, mlp_out, class_idx, sat_flag, done
  );

  modport slave (
    input  start, x, cfg_we, cfg_bias, cfg_layer, cfg_row, cfg_col, cfg_wdata,
    output busy, mlp_out, class_idx, sat_flag, done
  );
endinterface

// File: rtl/mlp_seq_engine.sv
// rtl/mlp_seq_engine.sv - multi-layer perceptron on one time-multiplexed MAC
module mlp_seq_engine #(
  parameter int NUM_FEATURES      = 4,
  parameter int HIDDEN_WIDTH      = 4,
  parameter int NUM_HIDDEN_LAYERS = 1,
  parameter int NUM_CLASSES       = 3,
  parameter int FP_TOTAL_BITS     = 16,
  parameter int FP_FRAC_BITS      = 8
) (
  input  logic               clk,
  input  logic               reset,
  mlp_seq_engine_if.slave    bus
);
  localparam int W     = FP_TOTAL_BITS;
  localparam int F     = FP_FRAC_BITS;
  localparam int NL    = NUM_HIDDEN_LAYERS + 1;
  localparam int D_FH  = (NUM_FEATURES > HIDDEN_WIDTH) ? NUM_FEATURES : HIDDEN_WIDTH;
  localparam int D     = (D_FH > NUM_CLASSES) ? D_FH : NUM_CLASSES;
  localparam int ACC_W = 2 * W + $clog2(D + 1);
  localparam int LW    = (NL > 1) ? $clog2(NL) : 1;
  localparam int CW    = (D > 1) ? $clog2(D) : 1;
  localparam int KW    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int NR    = 1 << CW;
  localparam int NLR   = 1 << LW;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]     W_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]     W_MIN   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                    state;

  // Parameter storage sized to the full address space so any cfg address is legal
  logic signed [W-1:0]       w_mem [NLR][NR][NR];
  logic signed [W-1:0]       b_mem [NLR][NR];

  // Ping-pong activation buffers; sel=0 means layer input is in act_a
  logic signed [W-1:0]       act_a [NR];
  logic signed [W-1:0]       act_b [NR];
  logic                      sel;

  logic [LW-1:0]             layer;
  logic [CW-1:0]             row;
  logic [CW-1:0]             col;
  logic signed [ACC_W-1:0]   acc;

  logic signed [W-1:0]       best_val;
  logic [KW-1:0]             best_idx;

  logic                      busy_r;
  logic                      done_r;
  logic                      sat_r;
  logic [NUM_CLASSES-1:0][W-1:0] out_r;
  logic [KW-1:0]             class_r;

  logic signed [W-1:0]       act_cur;
  logic signed [W-1:0]       w_cur;
  logic signed [W-1:0]       b_cur;
  logic signed [2*W-1:0]     prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   r_full;
  logic                      clip_hi;
  logic                      clip_lo;
  logic signed [W-1:0]       r_sat;
  logic signed [W-1:0]       r_act;
  logic                      last_layer;
  logic [CW-1:0]             n_in_last;
  logic [CW-1:0]             n_out_last;
  logic                      take_best;

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sat_flag  = sat_r;
  assign bus.mlp_out   = out_r;
  assign bus.class_idx = class_r;

  // Datapath: current product, neuron result with floor shift, clip and ReLU
  always_comb begin
    act_cur    = sel ? act_b[col] : act_a[col];
    w_cur      = w_mem[layer][row][col];
    b_cur      = b_mem[layer][row];
    prod       = $signed({{W{act_cur[W-1]}}, act_cur}) * $signed({{W{w_cur[W-1]}}, w_cur});
    prod_ext   = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    bias_ext   = {{(ACC_W-W){b_cur[W-1]}}, b_cur};
    sum        = acc + (bias_ext <<< F);
    r_full     = sum >>> F;
    clip_hi    = (r_full > SAT_MAX);
    clip_lo    = (r_full < SAT_MIN);
    last_layer = (layer == LW'(NL - 1));
    n_in_last  = (layer == '0) ? CW'(NUM_FEATURES - 1) : CW'(HIDDEN_WIDTH - 1);
    n_out_last = last_layer ? CW'(NUM_CLASSES - 1) : CW'(HIDDEN_WIDTH - 1);
    if (clip_hi) begin
      r_sat = W_MAX;
    end else if (clip_lo) begin
      r_sat = W_MIN;
    end else begin
      r_sat = r_full[W-1:0];
    end
    r_act = (!last_layer && r_sat[W-1]) ? '0 : r_sat;
    take_best = (row == '0) || (r_act > best_val);
  end

  // Config writes land only while idle; contents survive reset
  always_ff @(posedge clk) begin
    if (bus.cfg_we && state == S_IDLE) begin
      if (bus.cfg_bias) begin
        b_mem[bus.cfg_layer][bus.cfg_row] <= bus.cfg_wdata;
      end else begin
        w_mem[bus.cfg_layer][bus.cfg_row][bus.cfg_col] <= bus.cfg_wdata;
      end
    end
  end

  // Sequencer: one MAC per cycle, one WRITE per neuron, layer-by-layer
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sat_r    <= 1'b0;
      out_r    <= '0;
      class_r  <= '0;
      sel      <= 1'b0;
      layer    <= '0;
      row      <= '0;
      col      <= '0;
      acc      <= '0;
      best_val <= '0;
      best_idx <= '0;
      for (int i = 0; i < NR; i++) begin
        act_a[i] <= '0;
        act_b[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            for (int i = 0; i < NR; i++) begin
              if (i < NUM_FEATURES) begin
                act_a[i] <= bus.x[i];
              end else begin
                act_a[i] <= '0;
              end
            end
            acc    <= '0;
            sat_r  <= 1'b0;
            busy_r <= 1'b1;
            sel    <= 1'b0;
            layer  <= '0;
            row    <= '0;
            col    <= '0;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (col == n_in_last) begin
            col   <= '0;
            state <= S_WRITE;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_WRITE: begin
          acc <= '0;
          if (clip_hi || clip_lo) begin
            sat_r <= 1'b1;
          end
          if (last_layer) begin
            out_r[row] <= r_act;
            if (take_best) begin
              best_val <= r_act;
              best_idx <= KW'(row);
            end
          end else if (sel) begin
            act_a[row] <= r_act;
          end else begin
            act_b[row] <= r_act;
          end
          if (row == n_out_last) begin
            row <= '0;
            if (last_layer) begin
              class_r <= take_best ? KW'(row) : best_idx;
              done_r  <= 1'b1;
              state   <= S_DONE;
            end else begin
              layer <= layer + 1'b1;
              sel   <= ~sel;
              state <= S_MAC;
            end
          end else begin
            row   <= row + 1'b1;
            state <= S_MAC;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
